uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/tx_bit_timer.sv | 38 +++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = DATA_BITS + 2;

  // Index of the last data bit, sized for the 3-bit bit counter.
  function automatic logic [2:0] last_bit_idx();
    return 3'(DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags
// the final cycle of each bit; clear forces the count back to zero.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bit_end = enable && !clear && (count_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each held CLKS_PER_BIT clocks; registered serial line and done pulse.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_e state_reg;
  uart_state_e state_next;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_next;
  logic [2:0]  bit_idx_reg;
  logic [2:0]  bit_idx_next;
  logic        serial_reg;
  logic        serial_next;
  logic        done_reg;
  logic        done_next;
  logic        bit_end;
  logic        timer_en;
  logic        timer_clr;

  // Timer runs for the whole frame and is held at zero while idle, so the
  // accept edge always starts a fresh bit period.
  assign timer_en  = (state_reg != IDLE);
  assign timer_clr = (state_reg == IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (timer_en),
    .clear  (timer_clr),
    .bit_end(bit_end)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    serial_next  = serial_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        serial_next = STOP_BIT;
        if (tx_start) begin
          shift_next   = tx_data;
          bit_idx_next = '0;
          serial_next  = START_BIT;
          state_next   = START;
        end
      end

      START: begin
        if (bit_end) begin
          serial_next = shift_reg[0];
          state_next  = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == last_bit_idx()) begin
            serial_next = STOP_BIT;
            state_next  = STOP;
          end else begin
            // Present the next bit straight from the pre-shift value.
            shift_next   = {1'b0, shift_reg[7:1]};
            serial_next  = shift_reg[1];
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          serial_next = STOP_BIT;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end

      default: begin
        serial_next = STOP_BIT;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      shift_reg   <= 8'h00;
      bit_idx_reg <= '0;
      serial_reg  <= STOP_BIT;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      serial_reg  <= serial_next;
      done_reg    <= done_next;
    end
  end

  assign serial_out = serial_reg;
  assign tx_done    = done_reg;
  assign tx_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle frame checks on a 10-clock and a
// 4-clock instance, plus a mid-bit sampling receiver for loopback bytes.
module tb_uart_tx;

  logic       clk;
  logic       n_rst;
  logic       start_a;
  logic       start_b;
  logic [7:0] tx_data;
  logic       ser_a, busy_a, done_a;
  logic       ser_b, busy_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(.CLKS_PER_BIT(10)) dut_a (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (start_a),
    .tx_data   (tx_data),
    .serial_out(ser_a),
    .tx_busy   (busy_a),
    .tx_done   (done_a)
  );

  uart_tx #(.CLKS_PER_BIT(4)) dut_b (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (start_b),
    .tx_data   (tx_data),
    .serial_out(ser_b),
    .tx_busy   (busy_b),
    .tx_done   (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Observed {serial_out, tx_busy, tx_done} of the selected instance.
  function automatic logic [2:0] obs_line(input bit use_b);
    return use_b ? {ser_b, busy_b, done_b} : {ser_a, busy_a, done_a};
  endfunction

  // Sends one frame and checks it every cycle. Called mid-cycle with the
  // DUT idle; the next rising edge is the accept edge. Returns in the first
  // idle cycle after the frame. inject_k >= 0 pulses tx_start and changes
  // tx_data to 0x3C during that frame cycle.
  task automatic run_frame(input bit use_b, input logic [7:0] data, input bit hold,
                           input int inject_k, input string tag);
    int         n;
    logic [9:0] frame;
    logic [7:0] rx;
    logic       stop_bit;
    logic [2:0] obs;
    n        = use_b ? 4 : 10;
    frame    = {1'b1, data, 1'b0};
    rx       = 8'h00;
    stop_bit = 1'b0;
    tx_data  = data;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    for (int k = 0; k < 10 * n; k++) begin
      @(negedge clk);
      obs = obs_line(use_b);
      check({tag, "/line"}, 32'(obs), 32'({frame[k / n], 1'b1, 1'b0}));
      if (k % n == n / 2) begin
        if (k / n >= 1 && k / n <= 8) rx[k / n - 1] = obs[2];
        if (k / n == 9) stop_bit = obs[2];
      end
      if (inject_k >= 0 && k == inject_k) begin
        tx_data = 8'h3C;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (inject_k >= 0 && k == inject_k + 1) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    @(negedge clk);
    obs = obs_line(use_b);
    check({tag, "/done"}, 32'(obs), 32'(3'b101));
    check({tag, "/rx_byte"}, 32'(rx), 32'(data));
    check({tag, "/stop_bit"}, 32'(stop_bit), 32'(1'b1));
    $display("frame %s: data=0x%02h rx=0x%02h stop=%0b", tag, data, rx, stop_bit);
  endtask

  initial begin
    logic [7:0] rnd;
    n_rst   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tx_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/a", 32'(obs_line(1'b0)), 32'(3'b100));
    check("reset/b", 32'(obs_line(1'b1)), 32'(3'b100));
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle/a", 32'(obs_line(1'b0)), 32'(3'b100));
    $display("step reset: line_a=%03b line_b=%03b", obs_line(1'b0), obs_line(1'b1));

    // 0xA5 single frame, done in cycle 101
    run_frame(1'b0, 8'hA5, 1'b0, -1, "a5");
    repeat (3) @(negedge clk);

    // Back-to-back with tx_start held: one idle-high cycle between frames
    run_frame(1'b0, 8'h00, 1'b1, -1, "b2b_00");
    run_frame(1'b0, 8'hFF, 1'b0, -1, "b2b_ff");
    @(negedge clk);
    check("b2b/single_done", 32'(obs_line(1'b0)), 32'(3'b100));
    repeat (2) @(negedge clk);

    // Start pulse and data change mid-frame are ignored
    run_frame(1'b0, 8'h81, 1'b0, 39, "ignore_81");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("ignore/no_second", 32'(obs_line(1'b0)), 32'(3'b100));
    end
    $display("step ignore: no second frame after 0x81");

    // Reset in cycle 55 aborts the frame immediately
    tx_data = 8'hC3;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (55) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort/immediate", 32'(obs_line(1'b0)), 32'(3'b100));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort/held", 32'(obs_line(1'b0)), 32'(3'b100));
    end
    n_rst = 1'b1;
    $display("step abort: line=%03b after reset mid-frame", obs_line(1'b0));
    run_frame(1'b0, 8'h5A, 1'b0, -1, "after_reset_5a");
    repeat (2) @(negedge clk);

    // Four clocks per bit
    run_frame(1'b1, 8'h01, 1'b0, -1, "cpb4_01");
    check("cpb4/a_quiet", 32'(obs_line(1'b0)), 32'(3'b100));
    repeat (2) @(negedge clk);

    // Loopback through the sampling receiver
    for (int i = 0; i < 256; i++) begin
      rnd = 8'($urandom_range(0, 255));
      run_frame(1'b0, rnd, 1'b0, -1, "loop");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
